uart_fifo_256x8_sync: RTL and testbench
=======================================

Name: uart_fifo_256x8_sync

Overview:
- Single-clock synchronous byte FIFO for the UART transmit/receive data paths.
- Ring buffer of FIFO_DEPTH entries built on a synchronous-read RAM, with registered read data.
- Active-low read/write strobes.
- Provides full, empty and a programmable "at or above threshold" flag used for UART FIFO-level interrupts.

Parameters:
- FIFO_DEPTH, 256, number of RAM locations; usable capacity is FIFO_DEPTH-1 entries.
- FIFO_BITS, 8, width of pointers and occupancy counter (log2 FIFO_DEPTH).
- FIFO_WIDTH, 8, data word width.
- LEVEL, 128, threshold for the half flag; FIFO_BITS wide.

Ports:
- clock  input  1  single system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  FIFO_WIDTH  write data.
- write_n  input  1  write strobe, active low; one word per cycle while low.
- read_n  input  1  read strobe, active low; one word per cycle while low.
- data_out  output  FIFO_WIDTH  registered read data.
- full  output  1  high when counter == FIFO_DEPTH-1.
- empty  output  1  high when counter == 0.
- half  output  1  high when counter >= LEVEL.

Behaviour:
- State: wr_pointer, rd_pointer, counter (all FIFO_BITS), ram_q (FIFO_WIDTH), read_n_hold (1), data_out.
- Reset (reset high at a rising edge):
  - wr_pointer, rd_pointer, counter <= 0; read_n_hold <= 1; data_out <= 0.
  - After reset: empty=1, full=0; half=0 (for LEVEL>0).
  - RAM contents are not cleared.
  - Reset overrides any concurrent read or write.
- Flags are combinational decodes of counter.
- Accepted-operation rules:
  - wr_ok = !write_n && (!full || rd_ok).
  - rd_ok = !read_n && !empty.
- Write (wr_ok):
  - mem[wr_pointer] <= data_in.
  - wr_pointer advances, wrapping from FIFO_DEPTH-1 to 0.
- Read (rd_ok):
  - ram_q <= mem[rd_pointer].
  - rd_pointer advances, wrapping from FIFO_DEPTH-1 to 0.
- Counter:
  - +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
- Output register:
  - read_n_hold <= !rd_ok at every edge.
  - If read_n_hold == 0, data_out <= ram_q; otherwise data_out holds.
  - Read latency: strobe sampled at edge T; data visible on data_out after edge T+1.
  - Back-to-back reads deliver one word per cycle.
- Boundaries:
  - Write while full with no read: ignored. Pointers, counter and RAM are unchanged.
  - Read while empty: ignored. No pointer move; data_out is not updated.
  - Simultaneous read+write when empty: write only; counter 0->1.
  - Simultaneous read+write when full: both accepted; counter stays FIFO_DEPTH-1.
  - Same-cycle write and read of the same address cannot occur; a read requires the FIFO to be non-empty.
- LEVEL=0 makes half constantly high.

Optional Feature:
- Macro: FIFO_OVERFLOW_CHECK_EN.
- When defined, simulation-only checks, gated off while reset is high:
  - A write strobe while full with no accepted read prints "FIFO Overflow" with $time, then calls $stop.
  - A read strobe while empty prints "FIFO Underflow" with $time, then calls $stop.
- When undefined, no checking code is compiled. Functional behaviour is identical in both cases.

Test Plan:
- Reset, then idle -> empty=1, full=0, half=0, data_out=8'h00.
- Write 0x11,0x22,0x33 on consecutive cycles, then read 3 cycles back-to-back -> data_out shows 0x11, 0x22, 0x33 on successive cycles starting 2 edges after the first read strobe; empty returns to 1.
- Write 255 bytes 0x00..0xFE -> full=1 after the 255th write; half=1 from the 128th write. A 256th write of 0xFF is ignored; a subsequent read-out returns 0x00..0xFE.
- Fill and drain 300 words in a steady stream -> pointers wrap past 255; data order is preserved with no loss.
- Hold read_n and write_n low together:
  - when empty -> counter becomes 1;
  - when holding 5 words -> count stays 5 and data order is preserved;
  - when full -> count stays 255.
- Assert reset mid-stream with 10 words stored -> next edge: empty=1, data_out=0x00; a following read strobe is ignored.

Source files
------------

// File: rtl/uart_fifo_256x8_sync_if.sv
// -----------------------------------------------------------------------------
// uart_fifo_256x8_sync_if
//
// Purpose:
//   Bundles the data/strobe/flag signals of the UART byte FIFO so the FIFO and
//   its user connect through one port. Clock and reset are kept outside the
//   interface as plain scalar ports of the FIFO.
//
// Signals:
//   data_in   [FIFO_WIDTH-1:0]  write data                 (master -> slave)
//   write_n                     write strobe, active low   (master -> slave)
//   read_n                      read strobe, active low    (master -> slave)
//   data_out  [FIFO_WIDTH-1:0]  registered read data       (slave -> master)
//   full                        FIFO holds FIFO_DEPTH-1     (slave -> master)
//   empty                       FIFO holds no words        (slave -> master)
//   half                        occupancy >= LEVEL         (slave -> master)
//
// Modports:
//   master : the FIFO user (UART datapath or testbench)
//   slave  : the FIFO itself
// -----------------------------------------------------------------------------
interface uart_fifo_256x8_sync_if #(
  parameter int FIFO_WIDTH = 8
) ();

  logic [FIFO_WIDTH-1:0] data_in;
  logic                  write_n;
  logic                  read_n;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  half;

  modport master (
    output data_in,
    output write_n,
    output read_n,
    input  data_out,
    input  full,
    input  empty,
    input  half
  );

  modport slave (
    input  data_in,
    input  write_n,
    input  read_n,
    output data_out,
    output full,
    output empty,
    output half
  );

endinterface : uart_fifo_256x8_sync_if

// File: rtl/uart_fifo_256x8_sync.sv
// -----------------------------------------------------------------------------
// uart_fifo_256x8_sync
//
// Purpose:
//   Single-clock byte FIFO for the UART transmit/receive data paths. A ring
//   buffer of FIFO_DEPTH locations on a synchronous-read RAM; one location is
//   always left unused, so the usable capacity is FIFO_DEPTH-1 words. Read data
//   is registered twice (RAM output register, then data_out register), giving
//   a read latency of two edges: strobe sampled at edge T, data visible on
//   data_out after edge T+1. Back-to-back reads stream one word per cycle.
//
// Ports:
//   clock    in   single system clock, rising edge
//   reset    in   synchronous, active-high reset
//   fifo_if  slave modport of uart_fifo_256x8_sync_if:
//              data_in, write_n, read_n  (in)
//              data_out, full, empty, half (out)
//
// Parameters:
//   FIFO_DEPTH  number of RAM locations (power of two, 2**FIFO_BITS)
//   FIFO_BITS   pointer / occupancy counter width
//   FIFO_WIDTH  data word width
//   LEVEL       threshold for the half flag (half = count >= LEVEL;
//               LEVEL = 0 makes half constantly high)
//
// Optional feature (macro FIFO_OVERFLOW_CHECK_EN):
//   When defined, simulation-only checks report "FIFO Overflow" (write strobe
//   while full with no accepted read) and "FIFO Underflow" (read strobe while
//   empty) and stop the simulation. Checks are inactive while reset is high.
//   Functional behaviour is the same with or without the macro.
// -----------------------------------------------------------------------------
module uart_fifo_256x8_sync #(
  parameter int                   FIFO_DEPTH = 256,
  parameter int                   FIFO_BITS  = 8,
  parameter int                   FIFO_WIDTH = 8,
  parameter logic [FIFO_BITS-1:0] LEVEL      = FIFO_BITS'(128)
) (
  input  logic                  clock,
  input  logic                  reset,
  uart_fifo_256x8_sync_if.slave fifo_if
);

  localparam logic [FIFO_BITS-1:0] MAX_COUNT = FIFO_BITS'(FIFO_DEPTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [FIFO_BITS-1:0]  wr_ptr_q,      wr_ptr_d;
  logic [FIFO_BITS-1:0]  rd_ptr_q,      rd_ptr_d;
  logic [FIFO_BITS-1:0]  count_q,       count_d;
  logic                  read_n_hold_q, read_n_hold_d;
  logic [FIFO_WIDTH-1:0] data_out_q,    data_out_d;
  logic [FIFO_WIDTH-1:0] ram_q;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Flags and accepted-operation decode
  // ---------------------------------------------------------------------------
  logic full, empty, half;
  logic rd_ok, wr_ok;

  assign full  = (count_q == MAX_COUNT);
  assign empty = (count_q == '0);
  assign half  = (count_q >= LEVEL);

  // A read is only accepted with data present. A write into a full FIFO is
  // still accepted when a read frees a location in the same cycle; the read
  // and write addresses then differ, since the FIFO is non-empty.
  assign rd_ok = !fifo_if.read_n && !empty;
  assign wr_ok = !fifo_if.write_n && (!full || rd_ok);

  assign fifo_if.full     = full;
  assign fifo_if.empty    = empty;
  assign fifo_if.half     = half;
  assign fifo_if.data_out = data_out_q;

  function automatic logic [FIFO_BITS-1:0] next_ptr(input logic [FIFO_BITS-1:0] ptr);
    return (ptr == MAX_COUNT) ? '0 : ptr + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    data_out_d    = data_out_q;
    read_n_hold_d = !rd_ok;

    if (wr_ok) wr_ptr_d = next_ptr(wr_ptr_q);
    if (rd_ok) rd_ptr_d = next_ptr(rd_ptr_q);

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // ram_q was loaded by the read accepted on the previous edge; forward it.
    if (!read_n_hold_q) data_out_d = ram_q;
  end

  // ---------------------------------------------------------------------------
  // Control and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      read_n_hold_q <= 1'b1;
      data_out_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      read_n_hold_q <= read_n_hold_d;
      data_out_q    <= data_out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: synchronous-write, synchronous-read RAM
  // ---------------------------------------------------------------------------
  // NOTE: the RAM array and its output register are deliberately not reset;
  // a reset branch would stop the array mapping onto a RAM macro. Stale
  // contents are never visible because the pointers and counter are reset.
  always_ff @(posedge clock) begin
    if (!reset && wr_ok) mem[wr_ptr_q] <= fifo_if.data_in;
    if (!reset && rd_ok) ram_q         <= mem[rd_ptr_q];
  end

  // ---------------------------------------------------------------------------
  // Optional simulation-only overflow/underflow checks
  // ---------------------------------------------------------------------------
`ifdef FIFO_OVERFLOW_CHECK_EN
  always @(posedge clock) begin
    if (!reset) begin
      if (!fifo_if.write_n && full && !rd_ok) begin
        $display("FIFO Overflow at time %0t", $time);
        $stop;
      end
      if (!fifo_if.read_n && empty) begin
        $display("FIFO Underflow at time %0t", $time);
        $stop;
      end
    end
  end
`else
  // No checking logic in the default build.
`endif

endmodule : uart_fifo_256x8_sync

// File: tb/tb_uart_fifo_256x8_sync.sv
// -----------------------------------------------------------------------------
// tb_uart_fifo_256x8_sync
//
// Directed testbench for uart_fifo_256x8_sync. Inputs are driven on the
// falling edge; outputs are sampled on the falling edge after each rising
// edge. A small queue model tracks expected occupancy and read data; key
// points also carry hand-computed constants.
// -----------------------------------------------------------------------------
module tb_uart_fifo_256x8_sync;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  uart_fifo_256x8_sync_if #(.FIFO_WIDTH(8)) fifo_if ();

  uart_fifo_256x8_sync #(
    .FIFO_DEPTH(256),
    .FIFO_BITS (8),
    .FIFO_WIDTH(8),
    .LEVEL     (8'd128)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .fifo_if(fifo_if.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Expected state
  logic [7:0] mq[$];
  logic [7:0] m_ramq = 8'h00;
  logic       m_hold = 1'b1;
  logic [7:0] m_dout = 8'h00;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [2:0] exp_flags(input int n);
    return {n == 255, n == 0, n >= 128};
  endfunction

  // One clock cycle: drive at the falling edge, let a rising edge pass,
  // update the model, then compare at the next falling edge.
  task automatic step(input bit wr, input logic [7:0] d, input bit rd, input string tag);
    int n;
    bit rd_ok, wr_ok;
    n     = mq.size();
    rd_ok = rd && (n != 0);
    wr_ok = wr && ((n != 255) || rd_ok);
    fifo_if.write_n = !wr;
    fifo_if.read_n  = !rd;
    fifo_if.data_in = d;
    @(posedge clock);
    @(negedge clock);
    if (!m_hold) m_dout = m_ramq;
    if (rd_ok)   m_ramq = mq.pop_front();
    if (wr_ok)   mq.push_back(d);
    m_hold = !rd_ok;
    check({tag, "_flags"}, {fifo_if.full, fifo_if.empty, fifo_if.half}, exp_flags(mq.size()));
    check({tag, "_dout"},  fifo_if.data_out, m_dout);
  endtask

  task automatic do_reset(input bit wr, input bit rd);
    reset = 1'b1;
    fifo_if.write_n = !wr;
    fifo_if.read_n  = !rd;
    fifo_if.data_in = 8'hEE;
    @(posedge clock);
    @(negedge clock);
    mq.delete();
    m_hold = 1'b1;
    m_dout = 8'h00;
    reset  = 1'b0;
    fifo_if.write_n = 1'b1;
    fifo_if.read_n  = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fifo_if.data_in = 8'h00;
    fifo_if.write_n = 1'b1;
    fifo_if.read_n  = 1'b1;
    @(negedge clock);

    // 1. Reset and idle
    do_reset(1'b0, 1'b0);
    step(0, 8'h00, 0, "idle");
    check("rst_empty", fifo_if.empty, 1'b1);
    check("rst_full",  fifo_if.full,  1'b0);
    check("rst_half",  fifo_if.half,  1'b0);
    check("rst_dout",  fifo_if.data_out, 8'h00);

    // 2. Three writes, three back-to-back reads
    step(1, 8'h11, 0, "w3");
    step(1, 8'h22, 0, "w3");
    step(1, 8'h33, 0, "w3");
    check("w3_not_empty", fifo_if.empty, 1'b0);
    step(0, 8'h00, 1, "r3");
    check("r3_lat0", fifo_if.data_out, 8'h00);
    step(0, 8'h00, 1, "r3");
    check("r3_d0", fifo_if.data_out, 8'h11);
    step(0, 8'h00, 1, "r3");
    check("r3_d1", fifo_if.data_out, 8'h22);
    check("r3_empty", fifo_if.empty, 1'b1);
    step(0, 8'h00, 0, "r3");
    check("r3_d2", fifo_if.data_out, 8'h33);
    step(0, 8'h00, 1, "rd_empty");
    step(0, 8'h00, 0, "rd_empty");
    check("rd_empty_hold", fifo_if.data_out, 8'h33);

    // 3. Fill to capacity, overflow attempt, drain
    for (int i = 0; i < 255; i++) begin
      step(1, 8'(i), 0, "fill");
      if (i == 126) check("half_127", fifo_if.half, 1'b0);
      if (i == 127) check("half_128", fifo_if.half, 1'b1);
      if (i == 253) check("full_254", fifo_if.full, 1'b0);
    end
    check("full_255", fifo_if.full, 1'b1);
    step(1, 8'hFF, 0, "ovf");
    check("ovf_full", fifo_if.full, 1'b1);
    for (int i = 0; i < 255; i++) step(0, 8'h00, 1, "drain");
    step(0, 8'h00, 0, "drain");
    check("drain_last", fifo_if.data_out, 8'hFE);
    check("drain_empty", fifo_if.empty, 1'b1);

    // 4. Steady stream of 300 words across the pointer wrap
    for (int c = 0; c < 304; c++)
      step(c < 300, 8'(c) ^ 8'h5A, c >= 3, "stream");
    check("stream_empty", fifo_if.empty, 1'b1);
    check("stream_last", fifo_if.data_out, 8'(299) ^ 8'h5A);

    // 5a. Simultaneous read+write while empty: write only
    step(1, 8'hA0, 1, "sim_empty");
    check("sim_empty_cnt1", fifo_if.empty, 1'b0);
    // 5b. Hold 5 words, then three simultaneous cycles
    for (int i = 1; i < 5; i++) step(1, 8'hA0 + 8'(i), 0, "sim5_fill");
    for (int i = 0; i < 3; i++) step(1, 8'hB0 + 8'(i), 1, "sim5");
    check("sim5_size", mq.size(), 5);
    step(0, 8'h00, 0, "sim5");
    check("sim5_first", fifo_if.data_out, 8'hA2);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, "sim5_drain");
    step(0, 8'h00, 0, "sim5_drain");
    check("sim5_last", fifo_if.data_out, 8'hB2);
    // 5c. Simultaneous read+write while full
    for (int i = 0; i < 255; i++) step(1, 8'(i) + 8'h40, 0, "simf_fill");
    step(1, 8'hC3, 1, "simf");
    check("simf_full", fifo_if.full, 1'b1);
    for (int i = 0; i < 256; i++) step(0, 8'h00, 1, "simf_drain");
    step(0, 8'h00, 0, "simf_drain");
    check("simf_last", fifo_if.data_out, 8'hC3);

    // 6. Reset mid-stream with 10 words stored, strobes active during reset
    for (int i = 0; i < 10; i++) step(1, 8'h70 + 8'(i), 0, "pre_rst");
    do_reset(1'b1, 1'b1);
    check("mid_rst_empty", fifo_if.empty, 1'b1);
    check("mid_rst_full",  fifo_if.full,  1'b0);
    check("mid_rst_dout",  fifo_if.data_out, 8'h00);
    step(0, 8'h00, 1, "post_rst");
    step(0, 8'h00, 0, "post_rst");
    check("post_rst_dout",  fifo_if.data_out, 8'h00);
    check("post_rst_empty", fifo_if.empty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_fifo_256x8_sync
